// File: rtl/serial_add_arbiter_if.sv
// Handshake bundle for serial_add_arbiter: two operand request channels
// and one valid/ready result channel.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_sum, res_carry, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_sum, res_carry, res_id,
        input  res_ready
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Bit-serial adder shared by two requesters under round-robin arbitration;
// operands are consumed LSB-first, one bit per cycle, through a carry register.
module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_arbiter_if.slave  bus
);
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic [WIDTH-1:0]   res_sum_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               last_grant_r;
    logic               res_valid_r;
    logic               res_carry_r;
    logic               res_id_r;
    logic               grant0_s;
    logic               grant1_s;
    logic               last_bit_s;
    logic               s_s;
    logic               cout_s;
    logic [1:0]         ha1_s;
    logic [1:0]         ha2_s;

    // Half-adder cell: returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder on the current operand LSBs, built from two chained half adders
    always_comb begin
        ha1_s      = half_add(a_r[0], b_r[0]);
        ha2_s      = half_add(ha1_s[0], carry_r);
        s_s        = ha2_s[0];
        cout_s     = ha1_s[1] | ha2_s[1];
        last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic and round-robin grant; a tie goes to the requester not served last
    always_comb begin
        state_nxt_s = state_r;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n) begin
                    grant0_s = bus.req0_valid & (~bus.req1_valid | last_grant_r);
                    grant1_s = bus.req1_valid & (~bus.req0_valid | ~last_grant_r);
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
                if (grant0_s | grant1_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, serial shift datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r          <= '0;
            b_r          <= '0;
            sum_r        <= '0;
            cnt_r        <= '0;
            carry_r      <= 1'b0;
            last_grant_r <= 1'b1;
            res_valid_r  <= 1'b0;
            res_sum_r    <= '0;
            res_carry_r  <= 1'b0;
            res_id_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant0_s | grant1_s) begin
                        a_r          <= grant1_s ? bus.req1_a : bus.req0_a;
                        b_r          <= grant1_s ? bus.req1_b : bus.req0_b;
                        res_id_r     <= grant1_s;
                        last_grant_r <= grant1_s;
                        carry_r      <= 1'b0;
                        cnt_r        <= '0;
                    end
                end
                CALC: begin
                    a_r     <= a_r >> 1;
                    b_r     <= b_r >> 1;
                    sum_r   <= {s_s, sum_r[WIDTH-1:1]};
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        res_sum_r   <= {s_s, sum_r[WIDTH-1:1]};
                        res_carry_r <= cout_s;
                        res_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: res_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.res_valid  = res_valid_r;
    assign bus.res_sum    = res_sum_r;
    assign bus.res_carry  = res_carry_r;
    assign bus.res_id     = res_id_r;
endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Bit-serial N-bit adder built from two half-adder cells chained as a full adder, plus a carry register.
- Shares this one adder datapath between two requesters using round-robin arbitration.
- Sequences operands LSB-first over WIDTH cycles and returns sum, carry-out and requester ID on a valid/ready result port.
- Sits between operand producers and any consumer that needs low-area addition.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  WIDTH  requester 0 operand a
req0_b  in  WIDTH  requester 0 operand b
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 operands accepted this cycle
req1_a  in  WIDTH  requester 1 operand a
req1_b  in  WIDTH  requester 1 operand b
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_sum  out  WIDTH  (a+b) mod 2^WIDTH
res_carry  out  1  carry-out of bit WIDTH-1
res_id  out  1  requester that owns the result (0/1)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; res_valid=0, res_sum=0, res_carry=0, res_id=0.
  - carry register=0, bit counter=0, last_grant=1, so requester 0 wins the first tie.
  - req0_ready and req1_ready are forced 0 while rst_n is low.
- States:
  - IDLE: accepts requests. Grant rules:
    - Only one reqN_valid high: that requester gets ready.
    - Both high: ready goes to the requester != last_grant.
    - At most one ready is high in any cycle.
    - Ready is a combinational function of state, the valids and last_grant.
  - Handshake (reqN_valid and reqN_ready at a rising edge):
    - Capture a and b into shift registers; res_id<=N; last_grant<=N.
    - Carry register<=0, counter<=0, go to CALC.
  - CALC: both readies are 0. Each cycle handles bit i (LSB first):
    - HA1: p = a_i xor b_i, g = a_i and b_i.
    - HA2: s = p xor cin, t = p and cin.
    - cout = g or t.
    - s shifts into the sum register from the MSB side; the operands shift right; carry register<=cout; counter++.
    - After the WIDTH-th bit: res_carry<=final cout, res_sum takes the full sum, go to DONE.
  - DONE: res_valid=1.
    - res_sum, res_carry and res_id are held stable until res_ready.
    - On res_valid and res_ready: res_valid<=0, go to IDLE. Result registers keep their last value.
- Latency: acceptance edge T0. res_valid rises after edge T0+WIDTH, i.e. exactly WIDTH cycles later.
- Throughput: minimum one IDLE cycle after each result handshake. Back-to-back period is WIDTH+2 cycles when res_ready is held high.
- Requester valid dropping without a handshake has no effect. Changing operands while not granted is ignored.
- Backpressure: res_ready low in DONE stalls indefinitely with no state change and no new grants.
- Arithmetic: unsigned. Overflow wraps res_sum modulo 2^WIDTH; the overflow bit appears only on res_carry.
- Reset mid-CALC or mid-DONE: the operation is discarded, no result is emitted and all registers take reset values. The first post-reset request computes correctly, with no stale carry.
- Simultaneous events:
  - A valid arriving in the same cycle as the DONE→IDLE result handshake is not granted that cycle. It is granted in the following IDLE cycle.

Test Plan:
- WIDTH=8, req0 a=0x3C b=0x0F, res_ready=1 → req0_ready pulses one cycle; 8 cycles later res_valid=1, res_sum=0x4B, res_carry=0, res_id=0.
- WIDTH=8, req1 a=0xFF b=0x01 → res_sum=0x00, res_carry=1, res_id=1; req0_ready stays 0 throughout.
- Both valid out of reset: req0 0x10+0x20, req1 0x80+0x80.
  - First result: res_id=0, sum 0x30, carry 0.
  - Second result: res_id=1, sum 0x00, carry 1.
  - Both valid again → next grant goes to req0. Verify strict alternation over 6 transactions.
- Backpressure: hold res_ready=0 for 5 cycles in DONE → res_valid stays 1, res_sum, res_carry and res_id unchanged, both readies 0. Raise res_ready → one-cycle handshake, then IDLE.
- Assert rst_n=0 at bit 3 of 0xF0+0x1F → res_valid never rises, all outputs 0. After release, 0x01+0x01 → res_sum=0x02, res_carry=0.
- WIDTH=2, exhaustive: all 16 (a,b) pairs via alternating requesters → each {res_carry,res_sum} equals a+b; latency is 2 cycles every time.
